sound_decoder: RTL and testbench

//  Receive end of the speaker tone path: monitors a speaker square wave (spkr line), measures its period,

---
 rtl/sound_decoder.sv | 148 ++++++++++++++
 tb/tb_sound_decoder.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sound_decoder.sv
// sound_decoder: measures the speaker square-wave period, confirms LOW/MID/HIGH notes and spots FOOD/GAMEOVER jingles.
// Define SOUND_DECODER_DBG_EN to add the last_period/period_strobe debug ports.
module sound_decoder #(
    parameter int CLK_FREQ    = 50_000_000,
    parameter int NOTE_LOW    = 262,
    parameter int NOTE_MID    = 349,
    parameter int NOTE_HIGH   = 491,
    parameter int TOL_SHIFT   = 5,
    parameter int MIN_PERIODS = 4,
    parameter int SILENCE_CYC = 1_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        spkr_in,
    output logic [1:0]  note_id,
    output logic        note_strobe,
    output logic        food_det,
    output logic        over_det
`ifdef SOUND_DECODER_DBG_EN
    ,
    output logic [31:0] last_period,
    output logic        period_strobe
`endif
);
    localparam logic [31:0] NOM_L = 32'(CLK_FREQ / NOTE_LOW);
    localparam logic [31:0] NOM_M = 32'(CLK_FREQ / NOTE_MID);
    localparam logic [31:0] NOM_H = 32'(CLK_FREQ / NOTE_HIGH);
    localparam logic [31:0] LO_L  = NOM_L - (NOM_L >> TOL_SHIFT);
    localparam logic [31:0] HI_L  = NOM_L + (NOM_L >> TOL_SHIFT);
    localparam logic [31:0] LO_M  = NOM_M - (NOM_M >> TOL_SHIFT);
    localparam logic [31:0] HI_M  = NOM_M + (NOM_M >> TOL_SHIFT);
    localparam logic [31:0] LO_H  = NOM_H - (NOM_H >> TOL_SHIFT);
    localparam logic [31:0] HI_H  = NOM_H + (NOM_H >> TOL_SHIFT);
    localparam logic [31:0] SIL   = 32'(SILENCE_CYC);
    localparam logic [3:0]  MIN_P = 4'(MIN_PERIODS);
    localparam logic [1:0]  N_NONE = 2'd0;
    localparam logic [1:0]  N_LOW  = 2'd1;
    localparam logic [1:0]  N_MID  = 2'd2;
    localparam logic [1:0]  N_HIGH = 2'd3;

    typedef enum logic [1:0] {S_IDLE, S_N1, S_N2, S_N3} state_t;

    logic [2:0]  sync;
    logic [31:0] count;
    logic        rise, silence, armed, measure, confirm;
    logic [1:0]  cls, match_note;
    logic [3:0]  match_cnt, match_next;
    state_t      state, state_n;
    logic        pat_over, pat_over_n, food_n, over_n;

    assign rise    = sync[1] & ~sync[2];
    assign silence = (count == SIL) & ~rise;
    assign measure = rise & armed;

    // count holds the period length at the edge that closes it
    always_comb begin
        cls = (count >= LO_L && count <= HI_L) ? N_LOW :
              (count >= LO_M && count <= HI_M) ? N_MID :
              (count >= LO_H && count <= HI_H) ? N_HIGH : N_NONE;
        match_next = (cls == N_NONE) ? 4'd0 :
                     (cls == match_note && match_cnt != 4'd0) ?
                         ((match_cnt == 4'hf) ? match_cnt : match_cnt + 4'd1) : 4'd1;
        confirm = measure && cls != N_NONE && match_next >= MIN_P && cls != note_id;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync        <= '0;
            count       <= '0;
            armed       <= 1'b0;
            match_note  <= N_NONE;
            match_cnt   <= '0;
            note_id     <= N_NONE;
            note_strobe <= 1'b0;
        end else begin
            sync        <= {sync[1:0], spkr_in};
            note_strobe <= confirm;
            if (rise)
                count <= 32'd1;
            else if (count != SIL)
                count <= count + 32'd1;
            if (rise)
                armed <= 1'b1;
            if (measure) begin
                match_cnt <= match_next;
                if (cls != N_NONE)
                    match_note <= cls;
            end
            if (confirm)
                note_id <= cls;
            if (silence) begin
                armed     <= 1'b0;
                match_cnt <= '0;
                note_id   <= N_NONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            pat_over <= 1'b0;
            food_det <= 1'b0;
            over_det <= 1'b0;
        end else begin
            state    <= state_n;
            pat_over <= pat_over_n;
            food_det <= food_n;
            over_det <= over_n;
        end
    end

    // a note that does not continue the current jingle is re-evaluated as a possible first note
    always_comb begin
        state_n    = state;
        pat_over_n = pat_over;
        food_n     = 1'b0;
        over_n     = 1'b0;
        if (note_strobe) begin
            if (state == S_N1 && note_id == N_MID)
                state_n = S_N2;
            else if (state == S_N2 && note_id == (pat_over ? N_LOW : N_HIGH))
                state_n = S_N3;
            else if (note_id == N_LOW || note_id == N_HIGH) begin
                state_n    = S_N1;
                pat_over_n = (note_id == N_HIGH);
            end else
                state_n = S_IDLE;
        end else if (note_id == N_NONE && state != S_IDLE) begin
            state_n = S_IDLE;
            food_n  = (state == S_N3) & ~pat_over;
            over_n  = (state == S_N3) & pat_over;
        end
    end

`ifdef SOUND_DECODER_DBG_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            last_period   <= '0;
            period_strobe <= 1'b0;
        end else begin
            period_strobe <= measure;
            if (measure)
                last_period <= count;
        end
    end
`endif
endmodule

// File: tb/tb_sound_decoder.sv
// tb_sound_decoder: directed and randomized tone sequences checked every cycle against an event-level note/jingle model.
`timescale 1ns/1ps
module tb_sound_decoder;
    localparam int CLK_FREQ = 50_000;
    localparam int SIL      = 1_000;
    localparam int MINP     = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        spkr_in;
    logic [1:0]  note_id;
    logic        note_strobe, food_det, over_det;
`ifdef SOUND_DECODER_DBG_EN
    logic [31:0] last_period;
    logic        period_strobe;
`endif

    sound_decoder #(.CLK_FREQ(CLK_FREQ), .SILENCE_CYC(SIL)) dut (
        .clk(clk), .reset(reset), .spkr_in(spkr_in),
        .note_id(note_id), .note_strobe(note_strobe),
        .food_det(food_det), .over_det(over_det)
`ifdef SOUND_DECODER_DBG_EN
        , .last_period(last_period), .period_strobe(period_strobe)
`endif
    );

    always #5 clk = ~clk;

    int vectors = 0, miscompares = 0;
    int food_seen = 0, over_seen = 0, strobe_seen = 0;

    int t = 0, last_edge = 0, mnote = 0, mcnt = 0, exp_note = 0, exp_lp = 0;
    int p, n, r;
    bit armed = 0, e, exp_strobe = 0, exp_food = 0, exp_over = 0, pend_food = 0, pend_over = 0, exp_ps = 0;
    bit [2:0] h = '0;
    int notes[$];

    function automatic int nom_of(input int k);
        return k == 1 ? CLK_FREQ / 262 : k == 2 ? CLK_FREQ / 349 : CLK_FREQ / 491;
    endfunction

    function automatic int classify(input int per);
        for (int k = 1; k <= 3; k++) begin
            int d = per - nom_of(k);
            if ((d < 0 ? -d : d) <= (nom_of(k) >> 5))
                return k;
        end
        return 0;
    endfunction

    // Reads the confirmed notes since the last silence as tokens: L,M,H = FOOD, H,M,L = OVER;
    // a note that breaks a partial token starts over. Result is the jingle closed by the final token.
    function automatic int jingle_of();
        int i = 0, res = 0;
        while (i < notes.size()) begin
            res = 0;
            if ((notes[i] == 1 || notes[i] == 3) && i + 1 < notes.size() && notes[i+1] == 2) begin
                if (i + 2 < notes.size() && notes[i+2] == 4 - notes[i]) begin
                    res = (notes[i] == 1) ? 1 : 2;
                    i += 3;
                end else
                    i += 2;
            end else
                i += 1;
        end
        return res;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Model: edge events reach the decoder two posedges after the pin sample, period = distance between events.
    initial forever begin
        @(posedge clk);
        t++;
        exp_strobe = 0;
        exp_ps = 0;
        exp_food = pend_food;
        exp_over = pend_over;
        pend_food = 0;
        pend_over = 0;
        if (reset) begin
            h = '0;
            last_edge = t + 1;
            armed = 0; mcnt = 0; mnote = 0; exp_note = 0; exp_lp = 0;
            exp_food = 0; exp_over = 0;
            notes.delete();
        end else begin
            e = h[1] & ~h[2];
            h = {h[1:0], spkr_in};
            if (e) begin
                p = t - last_edge;
                last_edge = t;
                if (armed) begin
                    exp_ps = 1;
                    exp_lp = p;
                    n = classify(p);
                    if (n == 0)
                        mcnt = 0;
                    else begin
                        mcnt = (n == mnote && mcnt > 0) ? (mcnt < 15 ? mcnt + 1 : 15) : 1;
                        mnote = n;
                        if (mcnt >= MINP && n != exp_note) begin
                            exp_note = n;
                            exp_strobe = 1;
                            notes.push_back(n);
                        end
                    end
                end
                armed = 1;
            end else if (t - last_edge >= SIL) begin
                armed = 0;
                mcnt = 0;
                exp_note = 0;
                if (notes.size() > 0) begin
                    r = jingle_of();
                    pend_food = (r == 1);
                    pend_over = (r == 2);
                    notes.delete();
                end
            end
        end
        @(negedge clk);
        chk("note_id", note_id, exp_note);
        chk("note_strobe", note_strobe, exp_strobe);
        chk("food_det", food_det, exp_food);
        chk("over_det", over_det, exp_over);
`ifdef SOUND_DECODER_DBG_EN
        chk("last_period", last_period, exp_lp);
        chk("period_strobe", period_strobe, exp_ps);
`endif
        food_seen += food_det;
        over_seen += over_det;
        strobe_seen += note_strobe;
    end

    task automatic idle(input logic v, input int cyc);
        repeat (cyc) begin
            spkr_in = v;
            @(negedge clk);
        end
    endtask

    task automatic wave(input int per, input int cnt);
        repeat (cnt) begin
            idle(1'b1, per / 2);
            idle(1'b0, per - per / 2);
        end
    endtask

    task automatic note_burst(input int k, input int cnt);
        int tol = (nom_of(k) >> 5) + 2;
        repeat (cnt) wave(nom_of(k) - tol + int'($urandom_range(0, 2 * tol)), 1);
    endtask

    int s0, f0, o0;

    initial begin
        reset = 1'b1;
        spkr_in = 1'b0;
        for (int i = 0; i < 3; i++) idle(1'(i), 1);
        reset = 1'b0;
        idle(1'b0, 4);
        chk("reset_note_id", note_id, 0);
        chk("reset_no_strobe", strobe_seen, 0);

        s0 = strobe_seen;
        wave(190, 6);
        chk("low_note_id", note_id, 1);
        wave(190, 6);
        chk("low_single_strobe", strobe_seen - s0, 1);

        f0 = food_seen; o0 = over_seen;
        wave(190, 10); wave(143, 10); wave(101, 10);
        idle(1'b0, SIL + 20);
        chk("food_pulse", food_seen - f0, 1);
        chk("food_no_over", over_seen - o0, 0);
        chk("food_silence_note", note_id, 0);

        f0 = food_seen; o0 = over_seen;
        wave(101, 10); wave(143, 10); wave(190, 10);
        idle(1'b0, SIL + 20);
        chk("over_pulse", over_seen - o0, 1);
        chk("over_no_food", food_seen - f0, 0);

        f0 = food_seen; o0 = over_seen; s0 = strobe_seen;
        wave(190, 10); wave(143, 6); wave(120, 1); wave(143, 6);
        chk("glitch_note_held", note_id, 2);
        chk("glitch_strobes", strobe_seen - s0, 2);
        idle(1'b0, SIL + 20);
        chk("partial_no_detect", food_seen - f0 + over_seen - o0, 0);

        wave(190, 6); wave(1000, 2);
        chk("edge_beats_silence", note_id, 1);
        wave(1001, 2);
        chk("silence_at_threshold", note_id, 0);
        idle(1'b0, SIL + 20);

        f0 = food_seen; o0 = over_seen;
        wave(190, 10); wave(143, 10); wave(101, 3);
        reset = 1'b1;
        idle(1'b0, 2);
        reset = 1'b0;
        wave(101, 6);
        idle(1'b0, SIL + 20);
        chk("reset_mid_jingle", food_seen - f0 + over_seen - o0, 0);
`ifdef SOUND_DECODER_DBG_EN
        wave(143, 3);
        chk("dbg_last_period", last_period, 143);
`endif

        for (int k = 0; k < 25; k++) begin
            int a = int'($urandom_range(0, 9));
            if (a < 2) begin
                int first = (a == 0) ? 1 : 3;
                note_burst(first, int'($urandom_range(4, 6)));
                note_burst(2, int'($urandom_range(4, 6)));
                note_burst(4 - first, int'($urandom_range(4, 6)));
                if ($urandom_range(0, 1) == 1) idle(1'b0, SIL + 10);
            end else if (a < 6)
                note_burst(int'($urandom_range(1, 3)), int'($urandom_range(1, 8)));
            else if (a < 8)
                wave(int'($urandom_range(30, 250)), 1);
            else if (a == 8)
                idle(1'b0, int'($urandom_range(SIL - 5, SIL + 30)));
            else begin
                reset = 1'b1;
                idle(1'b0, int'($urandom_range(1, 3)));
                reset = 1'b0;
            end
        end
        idle(1'b0, SIL + 20);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
